// File: rtl/cic_decimator.sv
// CIC decimator for 1-bit delta-sigma bitstreams: incremental (integrators only) or free-running (full CIC).
// Optional macro CIC_SETTLE_MASK_EN masks the first ORDER free-running results after reset/start.
module cic_decimator #(
  parameter int ORDER      = 2,
  parameter int MAX_LOG2_M = 8,
  parameter int OUT_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             mode,
  input  logic [3:0]       log2_m,
  input  logic             start,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nxt;
  logic                    cfg_mode;
  logic [3:0]              cfg_log2m;
  logic [MAX_LOG2_M-1:0]   cnt;
  logic [MAX_LOG2_M-1:0]   cnt_mask;
  logic                    accept;
  logic                    dec_pt;
  logic                    emit;

  // integ_p0[k] holds integrator I(k+1); dly_p0[k] holds comb delay D(k+1)
  logic signed [OUT_W-1:0] integ_p0  [ORDER];
  logic signed [OUT_W-1:0] integ_sum [ORDER];
  logic signed [OUT_W-1:0] dly_p0    [ORDER];
  logic signed [OUT_W-1:0] comb_c    [ORDER+1];
  logic signed [OUT_W-1:0] data_p1;
  logic                    vld_p1;

  function automatic logic [3:0] clamp_log2m(input logic [3:0] l2);
    return (int'(l2) > MAX_LOG2_M) ? 4'(MAX_LOG2_M) : l2;
  endfunction

  // Counter compare value M-1 as a mask of log2(M) low ones
  always_comb begin
    cnt_mask = '0;
    for (int i = 0; i < MAX_LOG2_M; i++) begin
      cnt_mask[i] = (i < int'(cfg_log2m));
    end
  end

  assign accept = (state == RUN) && in_valid && !start;
  assign dec_pt = accept && (cnt == cnt_mask);

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else if (dec_pt && !cfg_mode) begin
      state_nxt = IDLE;
    end
  end

  // Stage p0: integrator cascade settles within one cycle
  always_comb begin
    integ_sum[0] = integ_p0[0] + signed'({{(OUT_W-1){1'b0}}, in_bit});
    for (int k = 1; k < ORDER; k++) begin
      integ_sum[k] = integ_p0[k] + integ_sum[k-1];
    end
  end

  // Comb section, evaluated only where a decimation point commits it
  always_comb begin
    comb_c[0] = integ_sum[ORDER-1];
    for (int k = 1; k <= ORDER; k++) begin
      comb_c[k] = comb_c[k-1] - dly_p0[k-1];
    end
  end

`ifdef CIC_SETTLE_MASK_EN
  logic [1:0] settle_cnt;
  logic       settled;

  assign emit = dec_pt && (!cfg_mode || settled);

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else if (dec_pt && cfg_mode && !settled) begin
      if (settle_cnt == 2'(ORDER-1)) begin
        settled <= 1'b1;
      end else begin
        settle_cnt <= settle_cnt + 2'd1;
      end
    end
  end
`else
  assign emit = dec_pt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_mode  <= mode;
      cfg_log2m <= clamp_log2m(log2_m);
      cnt       <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      for (int k = 0; k < ORDER; k++) begin
        integ_p0[k] <= '0;
        dly_p0[k]   <= '0;
      end
    end else begin
      state  <= state_nxt;
      vld_p1 <= emit;
      if (start) begin
        cfg_mode  <= mode;
        cfg_log2m <= clamp_log2m(log2_m);
        cnt       <= '0;
        for (int k = 0; k < ORDER; k++) begin
          integ_p0[k] <= '0;
          dly_p0[k]   <= '0;
        end
      end else if (accept) begin
        cnt <= dec_pt ? '0 : cnt + MAX_LOG2_M'(1);
        // Incremental conversions restart from zero; free-running wrap cancels in the combs
        for (int k = 0; k < ORDER; k++) begin
          integ_p0[k] <= (dec_pt && !cfg_mode) ? '0 : integ_sum[k];
        end
        if (dec_pt && cfg_mode) begin
          for (int k = 0; k < ORDER; k++) begin
            dly_p0[k] <= comb_c[k];
          end
        end
        // Stage p1: registered result and its strobe
        if (emit) begin
          data_p1 <= cfg_mode ? comb_c[ORDER] : integ_sum[ORDER-1];
        end
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign busy      = (state == RUN);

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Parametrised successor to the team's fixed 16-bit, order-2, M=16 decimator for 1-bit delta-sigma bitstreams.
- Provides a cascaded integrator-comb (CIC) filter with compile-time order and output width, and a runtime power-of-two decimation ratio.
- Two modes: incremental (one-shot conversion, integrators only) and free-running (full CIC with comb section).
- Sits between the 1-bit modulator input pin and the parallel output bus. Adds a sample-valid input, an output-valid strobe and a busy flag.

Parameters:
- ORDER, 2, number of integrator stages and comb stages; legal range 1..4.
- MAX_LOG2_M, 8, largest supported log2 of the decimation ratio.
- OUT_W, 24, integrator/comb/output width. Must satisfy OUT_W >= ORDER*MAX_LOG2_M+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  qualifies in_bit; a sample is accepted only on cycles where this is high.
- in_bit  in  1  modulator output; taken as unsigned 0/1.
- mode  in  1  0 = incremental, 1 = free-running CIC.
- log2_m  in  4  decimation ratio M = 2^log2_m; values above MAX_LOG2_M clamp to MAX_LOG2_M.
- start  in  1  one-cycle pulse: begin a conversion (incremental) or resynchronise (free-running).
- out_data  out  OUT_W  most recent decimated result; held between results.
- out_valid  out  1  one-cycle pulse when out_data updates.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all integrators, comb delays, sample counter, out_data and out_valid go to 0; busy = 0.
  - state goes to IDLE.
  - cfg_mode and cfg_log2m load from mode and log2_m on every reset cycle.
- Configuration: cfg_mode and cfg_log2m also load on every accepted start. Changes to mode or log2_m at any other time are ignored.
- States:
  - IDLE -> RUN on start.
  - RUN -> IDLE at the end of an incremental conversion.
  - A free-running conversion stays in RUN until reset or a start that selects incremental mode.
- start in any state:
  - clears integrators, comb delays and the counter;
  - loads the config and enters RUN.
  - If start and in_valid are high in the same cycle, start wins and the sample is discarded. No output is produced for an aborted conversion.
- Integrators (RUN and in_valid only): cascaded within one cycle.
  - I0' = in_bit; Ik' = Ik + I(k-1)' for k = 1..ORDER.
  - Arithmetic is modulo 2^OUT_W.
  - The counter increments per accepted sample and wraps at M.
- Decimation point: the accepted sample on which the counter equals M-1.
  - Incremental:
    - out_data <= I_ORDER' (registered on that edge); out_valid = 1 in the following cycle.
    - Integrators clear and state goes to IDLE.
    - Samples arriving in IDLE are ignored.
  - Free-running:
    - C0 = I_ORDER'; Ck = C(k-1) - Dk; Dk <= C(k-1).
    - out_data <= C_ORDER; out_valid pulses the next cycle.
    - Integrators are NOT cleared; wrap-around cancels in the combs.
- Latency: out_valid is asserted exactly 1 cycle after the clock edge that accepts the M-th sample.
- log2_m = 0 (M = 1): every accepted sample is a decimation point.
- Gaps in in_valid stall the filter with no state change.
- Steady-state free-running gain is M^ORDER (all-ones input -> M^ORDER).

Optional Feature:
- Macro: CIC_SETTLE_MASK_EN.
- Defined: in free-running mode, the first ORDER decimation points after reset or start update the comb delays but suppress out_data and out_valid. This masks the comb start-up transient. A 2-bit settle counter is added.
- Not defined: every decimation point produces out_valid. Incremental mode is unaffected either way.

Test Plan:
- Order 2. Reset with log2_m=4, mode=0. Pulse start, then 16 ones -> out_data=136, one out_valid pulse 1 cycle after the 16th sample, busy low afterwards; 5 further ones produce no output.
- Incremental, M=16, input 1,0,1,0,... starting with 1 -> out_data=72. Insert random in_valid gaps -> same result, produced 1 cycle after the 16th accepted sample.
- Free-running, log2_m=3, all ones, macro off -> outputs 36, 64, 64, 64 at samples 8, 16, 24, 32. Macro on -> first out_valid after sample 24 with value 64.
- Incremental: after 5 ones, pulse start (with in_valid high that cycle), then 16 ones -> exactly one output, 136. Change log2_m mid-conversion -> ignored.
- During free-running RUN, hold rst_n low 1 cycle -> next cycle out_data=0, out_valid=0, busy=0, state IDLE. Subsequent samples produce no output until start.
